// File: rtl/chan_mux_reorder_pkg.sv
// Shared types and the width-generic beat reorder helper for chan_mux_reorder.
package chan_mux_reorder_pkg;

    localparam int unsigned MAX_W = 512;

    typedef enum logic [1:0] {RO_NONE, RO_BIT, RO_NIB, RO_BYTE} reorder_mode_e;
    typedef enum logic [1:0] {S_EMPTY, S_BUSY, S_FULL} skid_state_e;

    // Operates on a zero-extended MAX_W vector: reverse the whole vector, then shift
    // right so the w live bits land back at the bottom (w is a multiple of 8).
    function automatic logic [MAX_W-1:0] reorder(input logic [MAX_W-1:0] d,
                                                 input reorder_mode_e     mode,
                                                 input int unsigned       w);
        logic [MAX_W-1:0] r;
        r = d;
        case (mode)
            RO_BIT:  r = {<<{d}};
            RO_NIB:  r = {<<4{d}};
            RO_BYTE: r = {<<8{d}};
            default: r = d;
        endcase
        if (mode != RO_NONE) begin
            r = r >> (MAX_W - w);
        end
        return r;
    endfunction

endpackage

// File: rtl/chan_mux_reorder_skid_buf.sv
// Two-entry skid buffer: valid/ready on both sides, input ready driven from state only.
module chan_mux_reorder_skid_buf
    import chan_mux_reorder_pkg::*;
#(
    parameter int unsigned W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         fire;

    assign in_ready_o  = (state_q != S_FULL);
    assign out_valid_o = (state_q != S_EMPTY);
    assign out_data_o  = out_q;
    assign accept      = in_valid_i && in_ready_o;
    assign fire        = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    out_d   = in_data_i;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (accept && fire) begin
                    out_d = in_data_i;
                end else if (accept) begin
                    skid_d  = in_data_i;
                    state_d = S_FULL;
                end else if (fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (fire) begin
                    out_d   = skid_q;
                    state_d = S_BUSY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/chan_mux_reorder.sv
// N-channel valid/ready mux with fixed or round-robin grant, per-beat reorder,
// skid-buffered output and a wrapping transfer counter.
module chan_mux_reorder
    import chan_mux_reorder_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [WIDTH-1:0]           in_data [NUM_CH],
    output logic [NUM_CH-1:0]          in_ready,
    input  logic [$clog2(NUM_CH)-1:0]  sel,
    input  logic                       arb_rr,
    input  reorder_mode_e              mode,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           xfer_cnt
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    if ((WIDTH % 8) != 0 || WIDTH > MAX_W) begin : g_width_chk
        $error("chan_mux_reorder: WIDTH must be a multiple of 8 and <= MAX_W");
    end
    if (NUM_CH < 2) begin : g_num_ch_chk
        $error("chan_mux_reorder: NUM_CH must be >= 2");
    end

    logic [CH_W-1:0]       grant;
    logic                  grant_vld;
    int unsigned           idx;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      xfer_cnt_q, xfer_cnt_d;
    logic [WIDTH-1:0]      sel_data;
    logic [MAX_W-1:0]      sel_wide;
    logic [WIDTH-1:0]      ro_data;
    logic                  skid_in_valid;
    logic                  skid_in_ready;
    logic                  accept;
    logic                  fire;
    logic [WIDTH+CH_W-1:0] skid_out;

    // grant_vld also covers sel values beyond NUM_CH-1 when NUM_CH is not a power of 2
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        if (!arb_rr) begin
            grant     = sel;
            grant_vld = (32'(sel) < NUM_CH);
        end else begin
            for (int unsigned i = 1; i <= NUM_CH; i++) begin
                idx = (32'(rr_ptr_q) + i) % NUM_CH;
                if (!grant_vld && in_valid[CH_W'(idx)]) begin
                    grant     = CH_W'(idx);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_data      = '0;
        skid_in_valid = 1'b0;
        in_ready      = '0;
        if (grant_vld) begin
            sel_data      = in_data[grant];
            skid_in_valid = in_valid[grant];
            in_ready[grant] = skid_in_ready && rst_n;
        end
        sel_wide = '0;
        sel_wide[WIDTH-1:0] = sel_data;
        ro_data  = WIDTH'(reorder(sel_wide, mode, WIDTH));
    end

    assign accept = skid_in_valid && skid_in_ready;
    assign fire   = out_valid && out_ready;

    always_comb begin
        rr_ptr_d   = accept ? grant : rr_ptr_q;
        xfer_cnt_d = fire ? xfer_cnt_q + 1'b1 : xfer_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            xfer_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    chan_mux_reorder_skid_buf #(
        .W (WIDTH + CH_W)
    ) u_skid_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (skid_in_valid),
        .in_data_i   ({grant, ro_data}),
        .in_ready_o  (skid_in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (skid_out),
        .out_ready_i (out_ready)
    );

    assign out_ch   = skid_out[WIDTH+CH_W-1:WIDTH];
    assign out_data = skid_out[WIDTH-1:0];
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_chan_mux_reorder.sv
// Directed bench for chan_mux_reorder (WIDTH=16, NUM_CH=4, CNT_W=8).
module tb_chan_mux_reorder;
    import chan_mux_reorder_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      in_valid;
    logic [15:0]     in_data [4];
    logic [3:0]      in_ready;
    logic [1:0]      sel;
    logic            arb_rr;
    reorder_mode_e   mode;
    logic            out_valid;
    logic [15:0]     out_data;
    logic [1:0]      out_ch;
    logic            out_ready;
    logic [7:0]      xfer_cnt;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    chan_mux_reorder #(
        .WIDTH  (16),
        .NUM_CH (4),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .sel       (sel),
        .arb_rr    (arb_rr),
        .mode      (mode),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] d,
                             input logic [1:0] ch, input logic [7:0] cnt);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            check({tag, ".data"}, 32'(out_data), 32'(d));
            check({tag, ".ch"}, 32'(out_ch), 32'(ch));
        end
        check({tag, ".cnt"}, 32'(xfer_cnt), 32'(cnt));
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 4'b0100;
        in_data[0] = 16'hA0A0;
        in_data[1] = 16'hB1B1;
        in_data[2] = 16'h1234;
        in_data[3] = 16'hC3C3;
        sel        = 2'd2;
        arb_rr     = 1'b0;
        mode       = RO_NONE;
        out_ready  = 1'b1;

        // reset state
        #2;
        check("rst.in_ready", 32'(in_ready), 32'h0);
        check_out("rst", 1'b0, 16'h0, 2'd0, 8'd0);
        check("rst.data", 32'(out_data), 32'h0);
        check("rst.ch", 32'(out_ch), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("t1.in_ready", 32'(in_ready), 32'b0100);

        // fixed select, each reorder mode
        tick();
        check_out("t1.none", 1'b1, 16'h1234, 2'd2, 8'd0);
        mode = RO_BIT;
        tick();
        check_out("t1.bit", 1'b1, 16'h2C48, 2'd2, 8'd1);
        mode = RO_NIB;
        tick();
        check_out("t1.nib", 1'b1, 16'h4321, 2'd2, 8'd2);
        mode = RO_BYTE;
        tick();
        check_out("t1.byte", 1'b1, 16'h3412, 2'd2, 8'd3);
        in_valid = 4'b0000;
        mode = RO_NONE;
        tick();
        check_out("t1.drain", 1'b0, 16'h0, 2'd0, 8'd4);

        // round robin, rr_ptr left at 2 by the fixed-select traffic
        arb_rr   = 1'b1;
        in_valid = 4'b1111;
        tick();
        check_out("t2.a", 1'b1, 16'hC3C3, 2'd3, 8'd4);
        tick();
        check_out("t2.b", 1'b1, 16'hA0A0, 2'd0, 8'd5);
        tick();
        check_out("t2.c", 1'b1, 16'hB1B1, 2'd1, 8'd6);
        in_valid = 4'b1011;
        tick();
        check_out("t2.skip2", 1'b1, 16'hC3C3, 2'd3, 8'd7);
        tick();
        check_out("t2.wrap", 1'b1, 16'hA0A0, 2'd0, 8'd8);
        tick();
        check_out("t2.d", 1'b1, 16'hB1B1, 2'd1, 8'd9);
        tick();
        check_out("t2.skip2b", 1'b1, 16'hC3C3, 2'd3, 8'd10);
        in_valid = 4'b0000;
        tick();
        check_out("t2.drain", 1'b0, 16'h0, 2'd0, 8'd11);

        // backpressure fills both entries, then drains in order
        arb_rr     = 1'b0;
        sel        = 2'd1;
        in_valid   = 4'b0010;
        in_data[1] = 16'h0001;
        out_ready  = 1'b0;
        #1;
        check("t3.rdy_empty", 32'(in_ready), 32'b0010);
        tick();
        check_out("t3.busy", 1'b1, 16'h0001, 2'd1, 8'd11);
        in_data[1] = 16'h0002;
        #1;
        check("t3.rdy_busy", 32'(in_ready), 32'b0010);
        tick();
        check_out("t3.full", 1'b1, 16'h0001, 2'd1, 8'd11);
        in_data[1] = 16'h0003;
        #1;
        check("t3.rdy_full", 32'(in_ready), 32'b0000);
        tick();
        check_out("t3.hold", 1'b1, 16'h0001, 2'd1, 8'd11);
        check("t3.rdy_hold", 32'(in_ready), 32'b0000);
        out_ready = 1'b1;
        tick();
        check_out("t3.rel1", 1'b1, 16'h0002, 2'd1, 8'd12);
        tick();
        check_out("t3.rel2", 1'b1, 16'h0003, 2'd1, 8'd13);
        in_valid = 4'b0000;
        tick();
        check_out("t3.drain", 1'b0, 16'h0, 2'd0, 8'd14);

        // counter wrap: 241 more transfers reach 255, one more wraps to 0
        in_valid = 4'b0010;
        repeat (242) tick();
        check("t4.cnt255", 32'(xfer_cnt), 32'd255);
        in_valid = 4'b0000;
        tick();
        check_out("t4.wrap", 1'b0, 16'h0, 2'd0, 8'd0);

        // async reset while full
        in_valid   = 4'b0010;
        in_data[1] = 16'h0055;
        tick();
        in_data[1] = 16'h0066;
        tick();
        out_ready  = 1'b0;
        in_data[1] = 16'h0077;
        tick();
        check_out("t5.full", 1'b1, 16'h0066, 2'd1, 8'd1);
        check("t5.rdy_full", 32'(in_ready), 32'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("t5.rst", 1'b0, 16'h0, 2'd0, 8'd0);
        check("t5.rst_data", 32'(out_data), 32'h0);
        check("t5.rst_rdy", 32'(in_ready), 32'h0);
        tick();
        check_out("t5.rst_hold", 1'b0, 16'h0, 2'd0, 8'd0);
        rst_n      = 1'b1;
        in_data[1] = 16'h0088;
        out_ready  = 1'b1;
        tick();
        check_out("t5.first", 1'b1, 16'h0088, 2'd1, 8'd0);
        in_valid = 4'b0000;
        tick();
        check_out("t5.drain", 1'b0, 16'h0, 2'd0, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
